// File: rtl/mul_seq_32.sv
// Iterative 32x32 unsigned shift-and-add multiplier built around one full_adder_32.
// Optional early termination when the remaining multiplier is zero: MUL_SEQ_EARLY_TERM_EN.

module full_adder_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_c,
  output logic [31:0] o_sum,
  output logic        o_c
);
  assign {o_c, o_sum} = 33'(i_a) + 33'(i_b) + 33'(i_c);
endmodule

module mul_seq_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state;
  logic [31:0] r_m;
  logic [31:0] r_q;
  logic [63:0] r_p;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_prod_hi;
  logic [31:0] r_prod_lo;

  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [63:0] w_p_step;
  logic [63:0] w_p_next;
  logic        w_early;
  logic        w_finish;

  assign w_addend = r_q[0] ? r_m : 32'd0;

  full_adder_32 u_adder (
    .i_a   (r_p[63:32]),
    .i_b   (w_addend),
    .i_c   (1'b0),
    .o_sum (w_sum),
    .o_c   (w_cout)
  );

  // Carry lands in P_hi[31], so the 64-bit accumulator never overflows.
  assign w_p_step = {w_cout, w_sum, r_p[31:1]};

`ifdef MUL_SEQ_EARLY_TERM_EN
  logic [63:0] w_p_shift;
  // Remaining iterations would only shift; collapse them into one shift.
  assign w_p_shift = r_p >> (6'd32 - r_cnt);
  assign w_early   = (r_q == 32'd0);
  assign w_p_next  = w_early ? w_p_shift : w_p_step;
`else
  assign w_early   = 1'b0;
  assign w_p_next  = w_p_step;
`endif

  assign w_finish = w_early || (r_cnt == 6'd31);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_m       <= 32'd0;
      r_q       <= 32'd0;
      r_p       <= 64'd0;
      r_cnt     <= 6'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_prod_hi <= 32'd0;
      r_prod_lo <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_p     <= 64'd0;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_p   <= w_p_next;
          r_q   <= r_q >> 1;
          r_cnt <= r_cnt + 6'd1;
          if (w_finish) begin
            r_prod_hi <= w_p_next[63:32];
            r_prod_lo <= w_p_next[31:0];
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign prod_hi = r_prod_hi;
  assign prod_lo = r_prod_lo;

endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: directed corner cases plus random operands
// checked against plain 64-bit multiplication and a latency rule derived from b.

module tb_mul_seq_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;

  int checks = 0;
  int errors = 0;

  mul_seq_32 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges from the accepting edge to the edge that raises done.
  function automatic int exp_lat(input logic [31:0] bv);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int h = -1;
    for (int i = 0; i < 32; i++) if (bv[i]) h = i;
    if (h < 0) return 1;
    return (h + 2 > 32) ? 32 : h + 2;
`else
    return 32;
`endif
  endfunction

  // Entered at the negedge right after the accepting edge; bounded wait.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv);
    int lat;
    int bn;
    logic [63:0] p;
    p = 64'(av) * 64'(bv);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(lat, bn);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(bv)));
    chk({tag, "_busy_cycles"}, 64'(bn), 64'(exp_lat(bv)));
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, "_prod"}, {prod_hi, prod_lo}, p);
    @(negedge clk);
    chk({tag, "_done_fall"}, 64'(done), 64'd0);
    chk({tag, "_prod_hold"}, {prod_hi, prod_lo}, p);
  endtask

  initial begin
    int lat1;
    int lat2;
    int bn;
    int ndone;
    logic [31:0] av;
    logic [31:0] bv;
    logic [63:0] seen;

    reset = 1'b1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {30'd0, busy, done, prod_hi, prod_lo}, 96'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {30'd0, busy, done, prod_hi, prod_lo}, 96'd0);

    run_op("3x5", 32'd3, 32'd5);
    run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("sparse", 32'h1010_1010, 32'h10);
    run_op("b_zero", 32'h583b_d1cc, 32'd0);
    run_op("a_zero", 32'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++) begin
      av = $urandom;
      bv = $urandom >> $urandom_range(0, 31);
      run_op("rand", av, bv);
    end

    // start pulses during RUN must be ignored; bit 31 of b keeps RUN long enough
    av = $urandom;
    bv = $urandom | 32'h8000_0000;
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    ndone = 0;
    seen = '0;
    for (int j = 0; j < 45; j++) begin
      start = (j == 5 || j == 20);
      a = $urandom;
      b = $urandom;
      if (done === 1'b1) begin
        ndone++;
        seen = {prod_hi, prod_lo};
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore_done_count", 64'(ndone), 64'd1);
    chk("ignore_prod", seen, 64'(av) * 64'(bv));
    chk("ignore_idle", 64'(busy), 64'd0);

    // asynchronous reset in the middle of iteration 10
    start = 1'b1;
    a = $urandom;
    b = $urandom | 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst_outputs", {30'd0, busy, done, prod_hi, prod_lo}, 96'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("midrst_no_activity", 64'(ndone), 64'd0);
    run_op("after_rst", 32'h1234_5678, 32'h9ABC_DEF0);

    // back-to-back: start held high into the DONE cycle with new operands
    start = 1'b1;
    a = 32'd3;
    b = 32'd5;
    @(negedge clk);
    wait_done(lat1, bn);
    chk("b2b_first_lat", 64'(lat1), 64'(exp_lat(32'd5)));
    chk("b2b_first_prod", {prod_hi, prod_lo}, 64'd15);
    a = 32'd7;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_reaccept", {62'd0, busy, done}, 64'd2);
    chk("b2b_prod_hold", {prod_hi, prod_lo}, 64'd15);
    wait_done(lat2, bn);
    chk("b2b_second_lat", 64'(lat2), 64'(exp_lat(32'd9)));
    chk("b2b_total_lat", 64'(lat1 + 1 + lat2), 64'(exp_lat(32'd5) + 1 + exp_lat(32'd9)));
    chk("b2b_second_prod", {prod_hi, prod_lo}, 64'd63);
    @(negedge clk);
    chk("b2b_end_idle", {62'd0, busy, done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
